// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder path: digit reversal, LOG4N derivation
// and read FSM encoding. Complex words are always packed as {real, imag}, real in the MSBs.
package fft_pkg;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

   // Number of base-4 digits in an index for a power-of-4 frame length.
   function automatic int fft_log4(input int n);
      return $clog2(n) / 2;
   endfunction

   function automatic logic [31:0] digit_rev(input logic [31:0] idx, input int log4n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < log4n; i++) begin
         r[2*i +: 2] = idx[2*(log4n-1-i) +: 2];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder banks: one write port, one registered read port.
// Address is {bank, index}; contents are never reset.
module fft_reorder_ram
   import fft_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_digit_reverse.sv
// Ping-pong reorder buffer turning base-4 digit-reversed FFT frames into natural order.
// Optional start-of-frame output enabled by defining FFT_DIGIT_REVERSE_SOF_EN.
module fft_digit_reverse
   import fft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 256
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             input_en,
   input  logic [WIDTH-1:0] input_real,
   input  logic [WIDTH-1:0] input_imag,
   output logic             output_en,
   output logic [WIDTH-1:0] output_real,
   output logic [WIDTH-1:0] output_imag
`ifdef FFT_DIGIT_REVERSE_SOF_EN
   ,
   output logic             output_sof
`endif
);

   localparam int LOG4N = fft_log4(N);
   localparam int AW    = $clog2(N);
   localparam int CW    = 2 * WIDTH;

   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    bank_full_q, bank_full_d;
   rd_state_e     state_q, state_d;
   logic          out_en_q, out_en_d;
   logic          sof_q, sof_d;

   logic          wr_last;
   logic          rd_issue;
   logic          rd_last;
   logic [AW:0]   wr_addr;
   logic [AW:0]   rd_addr;
   logic [CW-1:0] rd_data;

   // Write side: scatter each sample to its natural-order slot in the current bank.
   always_comb begin
      wr_last   = input_en && (wr_cnt_q == AW'(N - 1));
      wr_cnt_d  = input_en ? wr_cnt_q + AW'(1) : wr_cnt_q;
      wr_bank_d = wr_last ? ~wr_bank_q : wr_bank_q;
      wr_addr   = {wr_bank_q, AW'(digit_rev(32'(wr_cnt_q), LOG4N))};
   end

   assign rd_issue = (state_q == RD_READ);
   assign rd_last  = rd_issue && (rd_cnt_q == AW'(N - 1));

   // The writer and reader always work on different banks, so set and clear never collide.
   always_comb begin
      bank_full_d = bank_full_q;
      if (wr_last) begin
         bank_full_d[wr_bank_q] = 1'b1;
      end
      if (rd_last) begin
         bank_full_d[rd_bank_q] = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      case (state_q)
         RD_IDLE: begin
            if (bank_full_q[rd_bank_q]) begin
               state_d  = RD_READ;
               rd_cnt_d = '0;
            end
         end
         RD_READ: begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_last) begin
               rd_bank_d = ~rd_bank_q;
               if (!bank_full_q[~rd_bank_q]) begin
                  state_d = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_addr  = {rd_bank_q, rd_cnt_q};
      out_en_d = rd_issue;
      sof_d    = rd_issue && (rd_cnt_q == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= '0;
         state_q     <= RD_IDLE;
         out_en_q    <= 1'b0;
         sof_q       <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         state_q     <= state_d;
         out_en_q    <= out_en_d;
         sof_q       <= sof_d;
      end
   end

   fft_reorder_ram #(
      .AW (AW + 1),
      .DW (CW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (input_en),
      .wr_addr (wr_addr),
      .wr_data ({input_real, input_imag}),
      .rd_en   (rd_issue),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // RAM output register is not reset, so data is gated by the valid flag.
   assign output_en   = out_en_q;
   assign output_real = out_en_q ? rd_data[CW-1 -: WIDTH] : '0;
   assign output_imag = out_en_q ? rd_data[WIDTH-1:0]     : '0;

`ifdef FFT_DIGIT_REVERSE_SOF_EN
   assign output_sof = sof_q;
`else
   logic unused_sof;
   assign unused_sof = sof_q;
`endif

endmodule

// File: tb/tb_fft_digit_reverse.sv
// Directed bench for fft_digit_reverse: N=16 instance for frame/gap/reset cases,
// N=256 instance for three back-to-back frames.
module tb_fft_digit_reverse;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        en_a, oen_a;
   logic [15:0] ir_a, ii_a, or_a, oi_a;
   logic        en_b, oen_b;
   logic [15:0] ir_b, ii_b, or_b, oi_b;
`ifdef FFT_DIGIT_REVERSE_SOF_EN
   logic        sof_a, sof_b;
`endif

   fft_digit_reverse #(.WIDTH(16), .N(16)) u_dut_a (
      .clock       (clock),
      .reset       (reset),
      .input_en    (en_a),
      .input_real  (ir_a),
      .input_imag  (ii_a),
      .output_en   (oen_a),
      .output_real (or_a),
      .output_imag (oi_a)
`ifdef FFT_DIGIT_REVERSE_SOF_EN
      ,
      .output_sof  (sof_a)
`endif
   );

   fft_digit_reverse #(.WIDTH(16), .N(256)) u_dut_b (
      .clock       (clock),
      .reset       (reset),
      .input_en    (en_b),
      .input_real  (ir_b),
      .input_imag  (ii_b),
      .output_en   (oen_b),
      .output_real (or_b),
      .output_imag (oi_b)
`ifdef FFT_DIGIT_REVERSE_SOF_EN
      ,
      .output_sof  (sof_b)
`endif
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int qa_cyc[$], qa_re[$], qa_im[$], qa_sof[$];
   int qb_cyc[$], qb_re[$], qb_im[$];
   int sof_stray = 0;
   int sof_b_cnt = 0;

   always @(negedge clock) begin
      if (oen_a === 1'b1) begin
         qa_cyc.push_back(cyc);
         qa_re.push_back(int'(or_a));
         qa_im.push_back(int'(oi_a));
`ifdef FFT_DIGIT_REVERSE_SOF_EN
         qa_sof.push_back(int'(sof_a));
`else
         qa_sof.push_back(0);
`endif
      end
      if (oen_b === 1'b1) begin
         qb_cyc.push_back(cyc);
         qb_re.push_back(int'(or_b));
         qb_im.push_back(int'(oi_b));
      end
`ifdef FFT_DIGIT_REVERSE_SOF_EN
      if (sof_a === 1'b1 && oen_a !== 1'b1) sof_stray++;
      if (sof_b === 1'b1 && oen_b !== 1'b1) sof_stray++;
      if (sof_b === 1'b1) sof_b_cnt++;
`endif
   end

   function automatic int rev16(input int k);
      int t[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
      return t[k];
   endfunction

   function automatic int rev256(input int k);
      logic [7:0] b;
      logic [7:0] r;
      b = 8'(k);
      r = {b[1:0], b[3:2], b[5:4], b[7:6]};
      return int'(r);
   endfunction

   task automatic clear_a();
      qa_cyc.delete(); qa_re.delete(); qa_im.delete(); qa_sof.delete();
   endtask

   // Frame f, sample k carries value off0 + 16*f + rev16(k); called just after a rising edge.
   task automatic drive_a(input int off0, input int nsamp, input bit gap, output int last_edge);
      int v;
      last_edge = 0;
      for (int s = 0; s < nsamp; s++) begin
         v = off0 + 16 * (s / 16) + rev16(s % 16);
         en_a = 1'b1;
         ir_a = 16'(v);
         ii_a = 16'(-v);
         last_edge = cyc + 1;
         @(posedge clock); #1;
         if (gap) begin
            en_a = 1'b0;
            @(posedge clock); #1;
         end
      end
      en_a = 1'b0;
      ir_a = '0;
      ii_a = '0;
   endtask

   task automatic verify_a(input string tag, input int off0, input int nfr, input int first);
      int n;
      int v;
      check($sformatf("%s_count", tag), qa_cyc.size(), 16 * nfr);
      n = (qa_cyc.size() < 16 * nfr) ? qa_cyc.size() : 16 * nfr;
      for (int i = 0; i < n; i++) begin
         v = off0 + i;
         check($sformatf("%s_cyc%0d", tag, i), qa_cyc[i], first + i);
         check($sformatf("%s_re%0d", tag, i), qa_re[i], v & 'hFFFF);
         check($sformatf("%s_im%0d", tag, i), qa_im[i], (-v) & 'hFFFF);
`ifdef FFT_DIGIT_REVERSE_SOF_EN
         check($sformatf("%s_sof%0d", tag, i), qa_sof[i], (i % 16 == 0) ? 1 : 0);
`endif
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      int n;
      int errs;
      int first;
      int v;

      reset = 1'b1;
      en_a = 1'b0; ir_a = '0; ii_a = '0;
      en_b = 1'b0; ir_b = '0; ii_b = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_en_a", oen_a, 0);
      check("rst_re_a", or_a, 0);
      check("rst_im_a", oi_a, 0);
      check("rst_en_b", oen_b, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      clear_a();
      drive_a(0, 16, 1'b0, last);
      repeat (24) @(posedge clock); #1;
      verify_a("contig", 0, 1, last + 2);

      clear_a();
      drive_a(0, 16, 1'b1, last);
      repeat (24) @(posedge clock); #1;
      verify_a("gapped", 0, 1, last + 2);

      clear_a();
      drive_a(32, 32, 1'b0, last);
      repeat (24) @(posedge clock); #1;
      verify_a("b2b_a", 32, 2, last - 16 + 2);

      // Partial frame then reset; only the following full frame may appear.
      clear_a();
      drive_a(100, 7, 1'b0, last);
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_en0", oen_a, 0);
      check("rst_mid_re0", or_a, 0);
      @(posedge clock);
      @(negedge clock);
      check("rst_mid_en1", oen_a, 0);
      check("rst_mid_im1", oi_a, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      drive_a(200, 16, 1'b0, last);
      repeat (24) @(posedge clock); #1;
      verify_a("rst_mid", 200, 1, last + 2);

      // Reset while X[5] is on the output.
      clear_a();
      drive_a(300, 16, 1'b0, last);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cyc != last + 7 && n < 50);
      check("rdrst_wait", n < 50, 1);
      check("rdrst_x5_en", oen_a, 1);
      check("rdrst_x5_re", or_a, 305);
      reset = 1'b1;
      @(negedge clock);
      check("rdrst_en", oen_a, 0);
      check("rdrst_re", or_a, 0);
      check("rdrst_im", oi_a, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (30) @(posedge clock); #1;
      check("rdrst_count", qa_cyc.size(), 6);
      clear_a();
      drive_a(400, 16, 1'b0, last);
      repeat (24) @(posedge clock); #1;
      verify_a("rdrst_new", 400, 1, last + 2);

      // Three contiguous N=256 frames; frame f sample k carries 256*f + rev256(k).
      first = 0;
      for (int s = 0; s < 768; s++) begin
         v = 256 * (s / 256) + rev256(s % 256);
         en_b = 1'b1;
         ir_b = 16'(v);
         ii_b = 16'(-v);
         if (s == 255) first = cyc + 1 + 2;
         @(posedge clock); #1;
      end
      en_b = 1'b0; ir_b = '0; ii_b = '0;
      repeat (300) @(posedge clock); #1;
      check("b2b_b_count", qb_cyc.size(), 768);
      errs = 0;
      n = (qb_cyc.size() < 768) ? qb_cyc.size() : 768;
      for (int i = 0; i < n; i++) begin
         if (qb_cyc[i] != first + i) errs++;
         if (qb_re[i] != i) errs++;
         if (qb_im[i] != ((-i) & 'hFFFF)) errs++;
      end
      check("b2b_b_errs", errs, 0);
`ifdef FFT_DIGIT_REVERSE_SOF_EN
      check("b2b_b_sof_pulses", sof_b_cnt, 3);
      check("sof_stray", sof_stray, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
